// File: rtl/lfsr_spin_gen.sv
// lfsr_spin_gen
// Roulette-style random number generator between the debounced start button
// and the 7-segment decoder. A free-running counter seeds a Fibonacci LFSR
// when start is pressed. The LFSR is then stepped at a rate that halves each
// stage until the final value freezes. A second start press stops the spin early.
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous, active-high reset
//   i_start       one-cycle start/stop pulse
//   o_random_out  displayed value (low OUT_W bits of the LFSR)
//   o_busy        high while spinning
//   o_done        one-cycle pulse when a spin ends (natural or early stop)
//
// state | meaning
// IDLE  | waiting for start, output holds last value
// SPIN  | LFSR stepping with decelerating period

module lfsr_spin_gen #(
    parameter int               OUT_W           = 4,
    parameter int               LFSR_W          = 16,
    parameter logic [LFSR_W-1:0] TAPS           = 16'h002D,
    parameter int               BASE_PERIOD     = 4,
    parameter int               STAGES          = 4,
    parameter int               STEPS_PER_STAGE = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic [OUT_W-1:0] o_random_out,
    output logic             o_busy,
    output logic             o_done
);

    localparam int MAX_PERIOD = BASE_PERIOD << (STAGES - 1);
    localparam int TICK_W     = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
    localparam int STEP_W     = (STEPS_PER_STAGE > 1) ? $clog2(STEPS_PER_STAGE) : 1;
    localparam int STAGE_W    = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SPIN = 1'b1
    } state_t;

    state_t              state_q;
    logic [LFSR_W-1:0]   seed_q;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [TICK_W-1:0]   tick_q;
    logic [STEP_W-1:0]   step_q;
    logic [STAGE_W-1:0]  stage_q;
    logic [OUT_W-1:0]    out_q;
    logic                busy_q;
    logic                done_q;

    logic [LFSR_W-1:0]   lfsr_next;
    logic [31:0]         period_m1;
    logic                tick_last;
    logic                step_last;
    logic                stage_last;

    assign lfsr_next  = {^(lfsr_q & TAPS), lfsr_q[LFSR_W-1:1]};
    // Period doubles with every stage.
    assign period_m1  = (32'(BASE_PERIOD) << stage_q) - 32'd1;
    assign tick_last  = (32'(tick_q) == period_m1);
    assign step_last  = (step_q == STEP_W'(STEPS_PER_STAGE - 1));
    assign stage_last = (stage_q == STAGE_W'(STAGES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            seed_q  <= '0;
            lfsr_q  <= '0;
            tick_q  <= '0;
            step_q  <= '0;
            stage_q <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            seed_q <= seed_q + LFSR_W'(1);
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        // An all-zero LFSR would lock up, so a zero seed becomes 1.
                        lfsr_q  <= (seed_q == '0) ? LFSR_W'(1) : seed_q;
                        out_q   <= '0;
                        tick_q  <= '0;
                        step_q  <= '0;
                        stage_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SPIN;
                    end
                end
                SPIN: begin
                    if (i_start) begin
                        // Early stop takes priority over a coincident update.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (tick_last) begin
                        tick_q <= '0;
                        lfsr_q <= lfsr_next;
                        out_q  <= lfsr_next[OUT_W-1:0];
                        if (step_last) begin
                            step_q <= '0;
                            if (stage_last) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                stage_q <= stage_q + STAGE_W'(1);
                            end
                        end else begin
                            step_q <= step_q + STEP_W'(1);
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_random_out = out_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule
